// File: rtl/axis_sched_pkg.sv
// Shared constants for the frame scheduler: channel count, counter widths
// and the FSM state encoding.
package axis_sched_pkg;

  localparam int CH_NUM = 3;
  localparam int LINE_W = 12;
  localparam int FRM_W  = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARB  = 2'd1;
  localparam logic [1:0] SEEK = 2'd2;
  localparam logic [1:0] XFER = 2'd3;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin selector: first enabled channel after the last
// granted one, scanning 0 -> 1 -> 2 -> 0.
module axis_rr_pick
  import axis_sched_pkg::*;
(
  input  logic [1:0]        last,
  input  logic [CH_NUM-1:0] enable,
  output logic              valid,
  output logic [1:0]        idx
);

  logic [1:0] order [CH_NUM];

  always_comb begin
    case (last)
      2'd0:    order = '{2'd1, 2'd2, 2'd0};
      2'd1:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    valid = 1'b0;
    idx   = 2'd0;
    // Scan from lowest priority upward so the earliest candidate wins.
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (enable[order[i]]) begin
        valid = 1'b1;
        idx   = order[i];
      end
    end
  end

endmodule

// File: rtl/axis_frame_scheduler.sv
// Shares one AXI4-Stream DMA write port between three video sources, granting
// a whole frame at a time and emitting tlast only at end of frame.
module axis_frame_scheduler
  import axis_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic [2:0]            ch_enable,
  input  logic                  rr_mode,
  input  logic [1:0]            fix_sel,
  output logic                  s_axis_0_tready,
  input  logic                  s_axis_0_tlast,
  input  logic                  s_axis_0_tuser,
  input  logic                  s_axis_0_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_0_tdata,
  output logic                  s_axis_1_tready,
  input  logic                  s_axis_1_tlast,
  input  logic                  s_axis_1_tuser,
  input  logic                  s_axis_1_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_1_tdata,
  output logic                  s_axis_2_tready,
  input  logic                  s_axis_2_tlast,
  input  logic                  s_axis_2_tuser,
  input  logic                  s_axis_2_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_2_tdata,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [1:0]            cur_channel,
  output logic [LINE_W-1:0]     line_count,
  output logic [FRM_W-1:0]      frame_count,
  output logic                  busy,
  output logic                  sof_err
);

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(IMG_HEIGHT - 1);

  logic [1:0]            state;
  logic [1:0]            last_grant;
  logic                  first_beat;
  logic                  g_valid, g_last, g_user, g_ready;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  rr_valid, pick_valid, accept, mid_sof;
  logic [1:0]            rr_idx, fix_ch, pick_ch;
  logic [LINE_W-1:0]     eff_line;

  always_comb begin
    case (cur_channel)
      2'd1:    {g_valid, g_last, g_user, g_data} = {s_axis_1_tvalid, s_axis_1_tlast, s_axis_1_tuser, s_axis_1_tdata};
      2'd2:    {g_valid, g_last, g_user, g_data} = {s_axis_2_tvalid, s_axis_2_tlast, s_axis_2_tuser, s_axis_2_tdata};
      default: {g_valid, g_last, g_user, g_data} = {s_axis_0_tvalid, s_axis_0_tlast, s_axis_0_tuser, s_axis_0_tdata};
    endcase
  end

  axis_rr_pick u_pick (
    .last   (last_grant),
    .enable (ch_enable),
    .valid  (rr_valid),
    .idx    (rr_idx)
  );

  assign fix_ch     = (fix_sel == 2'd3) ? 2'd0 : fix_sel;
  assign pick_valid = rr_mode ? rr_valid : ch_enable[fix_ch];
  assign pick_ch    = rr_mode ? rr_idx : fix_ch;

  // SEEK drains pre-SOF beats but holds the SOF beat for XFER to forward.
  always_comb begin
    g_ready       = 1'b0;
    m_axis_tvalid = 1'b0;
    if (!s_axis_areset) begin
      case (state)
        SEEK:    g_ready = ~g_user;
        XFER: begin
          g_ready       = m_axis_tready;
          m_axis_tvalid = g_valid;
        end
        default: g_ready = 1'b0;
      endcase
    end
  end

  assign s_axis_0_tready = g_ready & (cur_channel == 2'd0);
  assign s_axis_1_tready = g_ready & (cur_channel == 2'd1);
  assign s_axis_2_tready = g_ready & (cur_channel == 2'd2);

  // A stray SOF restarts the frame at this beat, so it counts as line 0.
  assign mid_sof      = (state == XFER) & g_user & ~first_beat;
  assign eff_line     = mid_sof ? '0 : line_count;
  assign m_axis_tlast = (state == XFER) & g_last & (eff_line == LAST_LINE);
  assign m_axis_tdata = g_data;
  assign m_axis_tuser = g_user;
  assign accept       = g_valid & g_ready;
  assign busy         = (state == SEEK) | (state == XFER);

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state       <= IDLE;
      cur_channel <= 2'd0;
      last_grant  <= 2'd2;
      line_count  <= '0;
      frame_count <= '0;
      first_beat  <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      sof_err <= 1'b0;
      case (state)
        IDLE: state <= ARB;
        ARB: begin
          if (pick_valid) begin
            cur_channel <= pick_ch;
            last_grant  <= pick_ch;
            line_count  <= '0;
            state       <= SEEK;
          end
        end
        SEEK: begin
          if (g_valid && g_user) begin
            first_beat <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            first_beat <= 1'b0;
            sof_err    <= mid_sof;
            if (m_axis_tlast) begin
              frame_count <= frame_count + 1'b1;
              line_count  <= '0;
              state       <= ARB;
            end else begin
              line_count <= eff_line + {{(LINE_W-1){1'b0}}, g_last};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Scoreboard bench for axis_frame_scheduler: directed frames per source,
// expected m_axis beats queued up front and matched by an output monitor.
module tb_axis_frame_scheduler;

  localparam int DW  = 64;
  localparam int H   = 4;
  localparam int BPL = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
    logic [1:0]    ch;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_axis_areset = 1'b1;
  logic [2:0]    ch_enable = 3'b111;
  logic          rr_mode = 1'b1;
  logic [1:0]    fix_sel = 2'd0;
  logic          s0_tready, s1_tready, s2_tready;
  logic          s0_tlast = 0, s1_tlast = 0, s2_tlast = 0;
  logic          s0_tuser = 0, s1_tuser = 0, s2_tuser = 0;
  logic          s0_tvalid = 0, s1_tvalid = 0, s2_tvalid = 0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0, s2_tdata = '0;
  logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tready = 1'b1;
  logic [1:0]    cur_channel;
  logic [11:0]   line_count;
  logic [15:0]   frame_count;
  logic          busy, sof_err;

  axis_frame_scheduler #(.DATA_WIDTH(DW), .IMG_HEIGHT(H)) dut (
    .s_axis_aclk     (clk),
    .s_axis_areset   (s_axis_areset),
    .ch_enable       (ch_enable),
    .rr_mode         (rr_mode),
    .fix_sel         (fix_sel),
    .s_axis_0_tready (s0_tready),
    .s_axis_0_tlast  (s0_tlast),
    .s_axis_0_tuser  (s0_tuser),
    .s_axis_0_tvalid (s0_tvalid),
    .s_axis_0_tdata  (s0_tdata),
    .s_axis_1_tready (s1_tready),
    .s_axis_1_tlast  (s1_tlast),
    .s_axis_1_tuser  (s1_tuser),
    .s_axis_1_tvalid (s1_tvalid),
    .s_axis_1_tdata  (s1_tdata),
    .s_axis_2_tready (s2_tready),
    .s_axis_2_tlast  (s2_tlast),
    .s_axis_2_tuser  (s2_tuser),
    .s_axis_2_tvalid (s2_tvalid),
    .s_axis_2_tdata  (s2_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .cur_channel     (cur_channel),
    .line_count      (line_count),
    .frame_count     (frame_count),
    .busy            (busy),
    .sof_err         (sof_err)
  );

  beat_t q0[$], q1[$], q2[$];
  exp_t  exp_q[$];
  int    checks = 0, errors = 0;
  int    pop_count = 0, sof_cnt = 0, leak_cnt = 0;
  logic  rand_ready = 1'b0;

  function automatic logic [63:0] make_data(input int ch, input int fid, input int line, input int beat);
    return {16'hC0DE, 8'(ch), 8'(fid), 16'(line), 16'(beat)};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic push_src(input int ch, input beat_t bt);
    case (ch)
      1:       q1.push_back(bt);
      2:       q2.push_back(bt);
      default: q0.push_back(bt);
    endcase
  endtask

  // One well-formed frame: SOF on the first beat, tlast at the end of each line.
  task automatic load_frame(input int ch, input int fid, input bit expect_it);
    beat_t bt;
    exp_t  e;
    for (int l = 0; l < H; l++) begin
      for (int b = 0; b < BPL; b++) begin
        bt = '{data: make_data(ch, fid, l, b), user: (l == 0 && b == 0), last: (b == BPL - 1)};
        push_src(ch, bt);
        if (expect_it) begin
          e = '{data: bt.data, user: bt.user, last: (l == H - 1 && b == BPL - 1), ch: 2'(ch)};
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] en, input logic rr, input logic [1:0] fsel);
    @(posedge clk);
    #1;
    s_axis_areset = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
    rand_ready = 1'b0;
    ch_enable  = en;
    rr_mode    = rr;
    fix_sel    = fsel;
    repeat (3) @(posedge clk);
    #1;
    s_axis_areset = 1'b0;
    pop_count = 0; sof_cnt = 0; leak_cnt = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d beats still expected after %0d cycles", name, exp_q.size(), n);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int n = 0;
    while (pop_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (pop_count < target) begin
      errors++;
      $display("[TB] FAIL %s: only %0d of %0d beats seen", name, pop_count, target);
    end
  endtask

  // Source model: a queued beat is held until the DUT accepts it.
  initial begin
    logic a0, a1, a2;
    forever begin
      @(negedge clk);
      a0 = s0_tvalid & s0_tready;
      a1 = s1_tvalid & s1_tready;
      a2 = s2_tvalid & s2_tready;
      @(posedge clk);
      #1;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      if (a2 && q2.size() > 0) void'(q2.pop_front());
      s0_tvalid = (q0.size() > 0);
      s1_tvalid = (q1.size() > 0);
      s2_tvalid = (q2.size() > 0);
      {s0_tdata, s0_tuser, s0_tlast} = (q0.size() > 0) ? q0[0] : '0;
      {s1_tdata, s1_tuser, s1_tlast} = (q1.size() > 0) ? q1[0] : '0;
      {s2_tdata, s2_tuser, s2_tlast} = (q2.size() > 0) ? q2[0] : '0;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard match on each handshake plus stall stability.
  initial begin
    exp_t          e, got;
    logic          stall_v = 1'b0;
    logic [DW+1:0] stall_val = '0;
    forever begin
      @(negedge clk);
      if (s_axis_areset) begin
        stall_v = 1'b0;
      end else begin
        if (sof_err) sof_cnt++;
        if (s0_tready | s2_tready) leak_cnt++;
        if (stall_v)
          check_output("stall_hold", {61'd0, m_axis_tvalid, (m_axis_tdata == stall_val[DW+1:2]), (stall_val[1:0] == {m_axis_tuser, m_axis_tlast})}, 64'h7);
        if (m_axis_tvalid && m_axis_tready) begin
          got = '{data: m_axis_tdata, user: m_axis_tuser, last: m_axis_tlast, ch: cur_channel};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL beat: unexpected data=%h user=%b last=%b ch=%0d", got.data, got.user, got.last, got.ch);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("[TB] FAIL beat %0d: got data=%h user=%b last=%b ch=%0d, expected data=%h user=%b last=%b ch=%0d",
                       pop_count, got.data, got.user, got.last, got.ch, e.data, e.user, e.last, e.ch);
            end
          end
          pop_count++;
        end
        stall_v   = m_axis_tvalid & ~m_axis_tready;
        stall_val = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    beat_t bt;
    exp_t  e;

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_handshake", {58'd0, m_axis_tvalid, s0_tready, s1_tready, s2_tready, busy, sof_err}, 64'd0);
    check_output("reset_counters", {34'd0, cur_channel, line_count, frame_count}, 64'd0);

    // Round-robin over all channels: grants 0,1,2,0.
    apply_stimulus(3'b111, 1'b1, 2'd0);
    load_frame(0, 1, 1'b1);
    load_frame(1, 1, 1'b1);
    load_frame(2, 1, 1'b1);
    load_frame(0, 2, 1'b1);
    wait_drain("rr_drain", 2000);
    check_output("rr_frame_count", 64'(frame_count), 64'd4);

    // Fixed channel 1 with garbage ahead of SOF; other channels held off.
    apply_stimulus(3'b111, 1'b0, 2'd1);
    for (int i = 0; i < 3; i++) begin
      bt = '{data: make_data(1, 9, 99, i), user: 1'b0, last: (i == 1)};
      push_src(1, bt);
    end
    load_frame(1, 3, 1'b1);
    load_frame(0, 3, 1'b0);
    load_frame(2, 3, 1'b0);
    wait_drain("fix_drain", 1000);
    check_output("fix_frame_count", 64'(frame_count), 64'd1);
    check_output("fix_leak", 64'(leak_cnt), 64'd0);
    check_output("fix_q_sizes", {16'd0, 16'(q0.size()), 16'(q1.size()), 16'(q2.size())}, {16'd0, 16'd32, 16'd0, 16'd32});

    // Random output back-pressure.
    apply_stimulus(3'b111, 1'b1, 2'd0);
    rand_ready = 1'b1;
    load_frame(0, 4, 1'b1);
    load_frame(1, 4, 1'b1);
    load_frame(2, 4, 1'b1);
    wait_drain("bp_drain", 3000);
    rand_ready = 1'b0;
    check_output("bp_frame_count", 64'(frame_count), 64'd3);

    // Disable ch0 during line 2 of its frame: frame completes, ch0 skipped.
    apply_stimulus(3'b101, 1'b1, 2'd0);
    load_frame(0, 5, 1'b1);
    load_frame(0, 6, 1'b0);
    load_frame(2, 5, 1'b1);
    wait_pops("en_line2", 16, 500);
    #1;
    ch_enable = 3'b100;
    wait_drain("en_drain", 1000);
    check_output("en_frame_count", 64'(frame_count), 64'd2);
    check_output("en_ch0_held", 64'(q0.size()), 64'd32);

    // Stray SOF on line 2 beat 3 restarts the frame; fix_sel=3 selects ch0.
    apply_stimulus(3'b001, 1'b0, 2'd3);
    for (int l = 0; l < H + 2; l++) begin
      for (int b = 0; b < BPL; b++) begin
        bt = '{data: make_data(0, 7, l, b), user: ((l == 0 && b == 0) || (l == 2 && b == 3)), last: (b == BPL - 1)};
        push_src(0, bt);
        e = '{data: bt.data, user: bt.user, last: (l == H + 1 && b == BPL - 1), ch: 2'd0};
        exp_q.push_back(e);
      end
    end
    wait_pops("sof_inject", 20, 500);
    @(negedge clk);
    check_output("sof_line_count", 64'(line_count), 64'd0);
    check_output("sof_err_pulse", 64'(sof_err), 64'd1);
    wait_drain("sof_drain", 1000);
    check_output("sof_err_count", 64'(sof_cnt), 64'd1);
    check_output("sof_frame_count", 64'(frame_count), 64'd1);

    // One-cycle reset in the middle of ch1's frame.
    apply_stimulus(3'b111, 1'b1, 2'd0);
    load_frame(0, 8, 1'b1);
    load_frame(1, 8, 1'b1);
    load_frame(0, 9, 1'b1);
    wait_pops("rst_midframe", 42, 1000);
    check_output("rst_pre_frames", 64'(frame_count), 64'd1);
    #1;
    s_axis_areset = 1'b1;
    repeat (22) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    s_axis_areset = 1'b0;
    @(negedge clk);
    check_output("rst_outputs", {61'd0, m_axis_tvalid, busy, m_axis_tlast}, 64'd0);
    check_output("rst_frame_count", 64'(frame_count), 64'd0);
    wait_drain("rst_drain", 1000);
    check_output("rst_post_frames", 64'(frame_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_scheduler.md
Name: axis_frame_scheduler

Overview:
- Frame-aware scheduler that shares one AXI4-Stream DMA write port (m_axis_*) between three video stream sources.
- Sources are granted one whole frame at a time, in round-robin or fixed mode; ownership changes only at frame boundaries.
- Aligns each grant to start-of-frame (tuser) and counts lines.
- Asserts m_axis_tlast only on the last beat of line IMG_HEIGHT-1, so each DMA transfer is exactly one frame.

Parameters:
DATA_WIDTH, 64, stream data width in bits
IMG_HEIGHT, 480, lines per frame; legal range 1..4095

Ports:
s_axis_aclk  input  1  single clock
s_axis_areset  input  1  synchronous, active-high reset
ch_enable  input  3  per-channel enable; sampled only in ARB
rr_mode  input  1  1 = round-robin over enabled channels; 0 = fixed channel fix_sel; sampled only in ARB
fix_sel  input  2  fixed-mode channel; 3 is treated as 0
s_axis_N_tready  output  1  N = 0,1,2
s_axis_N_tlast  input  1  end of line
s_axis_N_tuser  input  1  start of frame
s_axis_N_tvalid  input  1
s_axis_N_tdata  input  DATA_WIDTH
m_axis_tvalid  output  1
m_axis_tdata  output  DATA_WIDTH
m_axis_tuser  output  1  start of frame, passed through
m_axis_tlast  output  1  end of frame
m_axis_tready  input  1
cur_channel  output  2  currently granted channel
line_count  output  12  lines completed in the current frame
frame_count  output  16  frames delivered; wraps at 2^16
busy  output  1  high in SEEK or XFER
sof_err  output  1  one-cycle pulse on an unexpected mid-frame tuser

Behaviour:
- Reset, synchronous: state=IDLE, cur_channel=0, line_count=0, frame_count=0, last granted=2 (so the first round-robin grant is ch0), sof_err=0.
- During reset all tready=0 and m_axis_tvalid=0.
- Reset asserted mid-frame aborts the frame immediately; no tlast is emitted.
- Datapath is combinational from the granted channel to m_axis, with zero latency. Grant and state are registered.
- Ungranted channels always see tready=0 (back-pressured, never dropped).
- Beat accepted = granted tvalid & tready.
- States and transitions:
  - IDLE: go to ARB the following cycle.
  - ARB (1 cycle):
    - rr_mode=1: pick the first enabled channel after the last granted one, in order 0→1→2→0.
    - rr_mode=0: pick fix_sel if that channel is enabled.
    - No eligible channel: stay in ARB.
    - Grant: latch cur_channel, line_count<=0, go to SEEK.
  - SEEK:
    - m_axis_tvalid=0; granted tready = ~tuser, so beats ahead of start-of-frame are discarded.
    - When granted tvalid&tuser is seen, that beat is held (not consumed); go to XFER next cycle.
  - XFER:
    - Pass-through: m_axis_tvalid=tvalid, granted tready=m_axis_tready.
    - Accepted beat with tlast: line_count+1.
    - m_axis_tlast = granted tlast & (line_count==IMG_HEIGHT-1).
    - Accepted beat with m_axis_tlast=1: frame_count+1, line_count<=0, go to ARB.
- Mid-frame tuser in XFER (accepted tuser on any beat other than the first beat of the frame):
  - sof_err pulses for one cycle; line_count<=0 (or 1 if the beat also carries tlast).
  - The frame restarts from that beat. No tlast is issued for the truncated frame; software recovers via sof_err.
- Configuration changes (ch_enable, rr_mode, fix_sel) mid-frame have no effect until the next ARB. The current frame always completes.
- m_axis_tvalid never depends on m_axis_tready. Data, tuser and tlast are stable while tvalid=1 & tready=0, inherited from the AXIS source.
- IMG_HEIGHT=1: every accepted tlast beat is a frame end.

Decomposition:
- Shared package axis_sched_pkg holds the state enum (IDLE, ARB, SEEK, XFER), CH_NUM=3, and the LINE_W=12 / FRM_W=16 width constants.
- One sub-module: axis_rr_pick, a combinational next-channel selector taking last grant and enable mask, returning valid + index.
- Mux, FSM and counters stay in the top level.

Test Plan:
- rr_mode=1, ch_enable=3'b111, IMG_HEIGHT=4, each source sends continuous 4-line frames of 8 beats per line → grants run 0,1,2,0; exactly one m_axis_tlast per 32 beats; frame_count=4 after 4 frames.
- rr_mode=0, fix_sel=1, ch1 sends 3 garbage beats then an SOF frame → the 3 garbage beats are consumed with m_axis_tvalid=0; the first m_axis beat has tuser=1; ch0/ch2 tready stay 0.
- Random m_axis_tready at 50%, IMG_HEIGHT=4 → no beat lost or duplicated (scoreboard match); tlast lands only on beat 32; data is stable during stalls.
- Clear ch_enable[0] during line 2 of a ch0 frame → that frame completes with tlast; the next grant skips ch0.
- tuser injected on line 2 beat 3 → sof_err pulses once; line_count=0; the following frame ends with tlast after 4 more lines.
- Assert s_axis_areset mid-XFER for 1 cycle → next cycle m_axis_tvalid=0, frame_count=0, state=IDLE; the following ARB grants ch0.
